// File: rtl/mem_byte_seq_pkg.sv
// Shared encodings and bus types for the byte-serial memory requester.
package mem_byte_seq_pkg;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic        True_v   = 1'b1;
  localparam logic        False_v  = 1'b0;

  typedef logic [7:0]  MemDataBus;
  typedef logic [31:0] InstAddrBus;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  // Index of the final byte of an access; the reserved size code behaves as a word.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    logic [1:0] r;
    case (size)
      SizeByte: r = 2'd0;
      SizeHalf: r = 2'd1;
      default:  r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte-serial memory requester: splits byte/half/word accesses into 8-bit bus cycles.
// state    | meaning
// IDLE     | no access; done_o pulses here after completion
// ISSUE    | presenting byte address k (and write data for stores)
// DRAIN    | load only: capture the final byte and form the extended result
module mem_byte_seq
  import mem_byte_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o,
  output logic [7:0]        mem_dout_o,
  input  logic [7:0]        mem_din_i
);

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic              we_q, sext_q, done_q, done_d, latch;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, rdata_d;
  logic [23:0]       lane_q, lane_d;
  logic [DATA_W-1:0] raw;
  MemDataBus         dout;

  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic sext,
                                           input logic [31:0] w);
    logic [31:0] r;
    case (size)
      SizeByte: r = {{24{sext & w[7]}}, w[7:0]};
      SizeHalf: r = {{16{sext & w[15]}}, w[15:0]};
      SizeWord: r = w;
      default:  r = w;
    endcase
    return r;
  endfunction

  // The last byte never lands in a lane register; it comes straight off the bus in DRAIN.
  always_comb begin
    case (size_q)
      SizeByte: raw = {24'h0, mem_din_i};
      SizeHalf: raw = {16'h0, mem_din_i, lane_q[7:0]};
      default:  raw = {mem_din_i, lane_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    done_d  = False_v;
    latch   = False_v;
    lane_d  = lane_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          state_d = ST_ISSUE;
          k_d     = 2'd0;
          latch   = True_v;
        end
      end
      ST_ISSUE: begin
        case (k_q)
          2'd1:    lane_d[7:0]   = mem_din_i;
          2'd2:    lane_d[15:8]  = mem_din_i;
          2'd3:    lane_d[23:16] = mem_din_i;
          default: lane_d = lane_q;
        endcase
        if (k_q == last_idx(size_q)) begin
          if (we_q) begin
            state_d = ST_IDLE;
            done_d  = True_v;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        done_d  = True_v;
        rdata_d = load_ext(size_q, sext_q, raw);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= 2'd0;
      done_q  <= False_v;
      we_q    <= False_v;
      sext_q  <= False_v;
      size_q  <= SizeByte;
      addr_q  <= '0;
      wdata_q <= '0;
      lane_q  <= '0;
      rdata_q <= ZeroWord;
    end else if (rdy) begin
      state_q <= state_d;
      k_q     <= k_d;
      done_q  <= done_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
      if (latch) begin
        we_q    <= we_i;
        sext_q  <= sext_i;
        size_q  <= size_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  assign dout       = wdata_q[{k_q, 3'b000} +: 8];
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q & rdy & (state_q == ST_IDLE);
  assign rdata_o    = rdata_q;
  assign mem_a_o    = (state_q == ST_IDLE) ? '0 : addr_q + ADDR_W'(k_q);
  assign mem_wr_o   = (state_q == ST_ISSUE) & we_q & rdy;
  assign mem_dout_o = ((state_q == ST_ISSUE) && we_q) ? dout : 8'h00;

endmodule

// File: tb/tb_mem_byte_seq.sv
// Bench for mem_byte_seq: byte-wide memory model plus a reference of whole accesses.
module tb_mem_byte_seq;

  logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0, sext_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        busy_o, done_o, mem_wr_o;
  logic [31:0] rdata_o, mem_a_o;
  logic [7:0]  mem_dout_o;
  logic [7:0]  mem_din_i = 8'h00;

  int checks = 0, failures = 0;
  logic [7:0]  mem     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] exp_rdata = '0;

  mem_byte_seq dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .sext_i(sext_i), .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .rdata_o(rdata_o), .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o), .mem_dout_o(mem_dout_o),
    .mem_din_i(mem_din_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Synchronous byte RAM; read data follows the address by one cycle and freezes with rdy.
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr_o) mem[mem_a_o] = mem_dout_o;
      mem_din_i <= rd_mem(mem_a_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One access, starting and ending at a falling edge; cycles fz_at..fz_at+fz_len-1 have rdy=0.
  task automatic access(input logic we, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int fz_at, input int fz_len);
    int n, p, done_p;
    logic [31:0] result;
    logic frozen;
    bit seen;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    done_p = we ? n + 1 : n + 2;
    result = exp_rdata;
    if (!we) begin
      result = '0;
      for (int i = 0; i < n; i++) result = result | ({24'h0, rd_ref(addr + i)} << (8 * i));
      if (sext && n < 4 && result[8 * n - 1]) result = result | (32'hFFFF_FFFF << (8 * n));
    end else begin
      for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8 * i +: 8];
    end
    req_i = 1'b1; we_i = we; size_i = size; sext_i = sext; addr_i = addr; wdata_i = wdata;
    rdy = 1'b1;
    @(posedge clk);
    p = 1;
    seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      #1;
      req_i = 1'b0;
      frozen = (c >= fz_at) && (c < fz_at + fz_len);
      rdy = !frozen;
      @(negedge clk);
      if (p == done_p) begin
        chk("done_pulse", {31'h0, done_o}, {31'h0, !frozen});
        chk("busy_idle", {31'h0, busy_o}, 32'h0);
        chk("addr_idle", mem_a_o, 32'h0);
        chk("wr_idle", {31'h0, mem_wr_o}, 32'h0);
        if (!frozen) begin
          chk("rdata", rdata_o, result);
          seen = 1;
        end
      end else begin
        chk("done_early", {31'h0, done_o}, 32'h0);
        chk("busy", {31'h0, busy_o}, 32'h1);
        chk("rdata_hold", rdata_o, exp_rdata);
        chk("bus_addr", mem_a_o, addr + ((p <= n) ? p - 1 : n - 1));
        chk("bus_wr", {31'h0, mem_wr_o}, {31'h0, (!frozen && we && p <= n)});
        if (we && p <= n) chk("bus_dout", {24'h0, mem_dout_o}, {24'h0, wdata[8 * (p - 1) +: 8]});
      end
      if (!frozen) p++;
      if (!seen) @(posedge clk);
    end
    chk("done_seen", {31'h0, seen}, 32'h1);
    exp_rdata = result;
    if (we) for (int i = -1; i <= n; i++) chk("mem_byte", {24'h0, rd_mem(addr + i)}, {24'h0, rd_ref(addr + i)});
  endtask

  initial begin
    logic [31:0] ra;
    #12;
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_addr", mem_a_o, 32'h0);
    chk("rst_wr", {31'h0, mem_wr_o}, 32'h0);
    chk("rst_dout", {24'h0, mem_dout_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy = 1'b1;
    mem[32'h1000] = 8'h11; mem[32'h1001] = 8'h22; mem[32'h1002] = 8'h33; mem[32'h1003] = 8'h44;
    ref_mem[32'h1000] = 8'h11; ref_mem[32'h1001] = 8'h22;
    ref_mem[32'h1002] = 8'h33; ref_mem[32'h1003] = 8'h44;
    mem[32'h20] = 8'h80; ref_mem[32'h20] = 8'h80;

    access(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 0, 0);
    chk("word_load", rdata_o, 32'h4433_2211);
    access(1'b0, 2'b00, 1'b1, 32'h0000_0020, 32'h0, 0, 0);
    chk("byte_sext", rdata_o, 32'hFFFF_FF80);
    access(1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0, 0, 0);
    chk("byte_zext", rdata_o, 32'h0000_0080);
    access(1'b1, 2'b01, 1'b0, 32'h0000_0030, 32'hDEAD_BEEF, 0, 0);
    chk("half_store_rdata", rdata_o, 32'h0000_0080);
    access(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_BABE, 0, 0);
    access(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 0, 0);
    chk("wrap_load", rdata_o, 32'hCAFE_BABE);
    access(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 2, 3);
    chk("frozen_load", rdata_o, 32'h4433_2211);

    // Reset in the middle of a word store: only byte 0 reaches memory.
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; addr_i = 32'h40; wdata_i = 32'h0BAD_F00D;
    @(posedge clk); #1 req_i = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy_o}, 32'h0);
    chk("arst_done", {31'h0, done_o}, 32'h0);
    chk("arst_addr", mem_a_o, 32'h0);
    chk("arst_wr", {31'h0, mem_wr_o}, 32'h0);
    chk("arst_dout", {24'h0, mem_dout_o}, 32'h0);
    chk("arst_rdata", rdata_o, 32'h0);
    ref_mem[32'h40] = 8'h0D;
    exp_rdata = '0;
    repeat (2) begin
      @(negedge clk);
      chk("arst_no_done", {31'h0, done_o}, 32'h0);
    end
    rst_n = 1'b1;
    chk("arst_byte0", {24'h0, rd_mem(32'h40)}, {24'h0, rd_ref(32'h40)});
    chk("arst_byte1", {24'h0, rd_mem(32'h41)}, {24'h0, rd_ref(32'h41)});
    access(1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 0, 0);
    access(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 0, 0);
    chk("after_rst_load", rdata_o, 32'h0000_1234);

    for (int t = 0; t < 40; t++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
      if ($urandom_range(0, 2) == 0)
        access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ra, $urandom, $urandom_range(1, 6), $urandom_range(1, 3));
      else
        access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ra, $urandom, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
